// File: rtl/butterfly10.sv
// First radix-2 DIF butterfly of the 512-point, 16-lane FFT: pairs x[n] with x[n+256],
// streams the 16 sum blocks during the second half, then drains the 16 difference blocks.
module butterfly10 (
    input  logic         clk,
    input  logic         rstn,
    input  logic         valid_in,
    input  logic [143:0] din_i,
    input  logic [143:0] din_q,
    output logic [207:0] dout_i,
    output logic [207:0] dout_q,
    output logic         valid_out
);
    localparam int BLK  = 16;
    localparam int IW   = 9;
    localparam int BW   = 10;
    localparam int OW   = 13;
    localparam int HALF = 16;

    logic [BLK*BW-1:0] buf_i [0:HALF-1];
    logic [BLK*BW-1:0] buf_q [0:HALF-1];

    logic [4:0] in_cnt;
    logic [3:0] drain_cnt;
    logic       drain_active;

    logic [BLK*BW-1:0] a_i, a_q, r_i, r_q, wr_i, wr_q;
    logic [BLK*OW-1:0] sum_i, sum_q, drn_i, drn_q;

    // The first half stores the sign-extended input; the second half overwrites it with A-B.
    always_comb begin
        logic [BW-1:0] b_i, b_q, s_i, s_q, d_i, d_q;
        b_i = '0;
        b_q = '0;
        s_i = '0;
        s_q = '0;
        d_i = '0;
        d_q = '0;
        a_i = buf_i[in_cnt[3:0]];
        a_q = buf_q[in_cnt[3:0]];
        r_i = buf_i[drain_cnt];
        r_q = buf_q[drain_cnt];
        wr_i  = '0;
        wr_q  = '0;
        sum_i = '0;
        sum_q = '0;
        drn_i = '0;
        drn_q = '0;
        for (int k = 0; k < BLK; k++) begin
            b_i = {din_i[k*IW+IW-1], din_i[k*IW +: IW]};
            b_q = {din_q[k*IW+IW-1], din_q[k*IW +: IW]};
            s_i = a_i[k*BW +: BW] + b_i;
            s_q = a_q[k*BW +: BW] + b_q;
            d_i = a_i[k*BW +: BW] - b_i;
            d_q = a_q[k*BW +: BW] - b_q;
            wr_i[k*BW +: BW]  = in_cnt[4] ? d_i : b_i;
            wr_q[k*BW +: BW]  = in_cnt[4] ? d_q : b_q;
            sum_i[k*OW +: OW] = {{(OW-BW){s_i[BW-1]}}, s_i};
            sum_q[k*OW +: OW] = {{(OW-BW){s_q[BW-1]}}, s_q};
            drn_i[k*OW +: OW] = {{(OW-BW){r_i[k*BW+BW-1]}}, r_i[k*BW +: BW]};
            drn_q[k*OW +: OW] = {{(OW-BW){r_q[k*BW+BW-1]}}, r_q[k*BW +: BW]};
        end
    end

    // Non-blocking write gives read-before-write when a new frame overwrites the entry being drained.
    always_ff @(posedge clk) begin
        if (!rstn && valid_in) begin
            buf_i[in_cnt[3:0]] <= wr_i;
            buf_q[in_cnt[3:0]] <= wr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            in_cnt       <= '0;
            drain_cnt    <= '0;
            drain_active <= 1'b0;
            valid_out    <= 1'b0;
            dout_i       <= '0;
            dout_q       <= '0;
        end else begin
            valid_out <= 1'b0;
            if (valid_in) begin
                in_cnt <= in_cnt + 5'd1;
                if (in_cnt[4]) begin
                    dout_i    <= sum_i;
                    dout_q    <= sum_q;
                    valid_out <= 1'b1;
                end
            end
            // Sums of a new frame cannot begin until 16 blocks after the drain starts.
            if (drain_active) begin
                dout_i    <= drn_i;
                dout_q    <= drn_q;
                valid_out <= 1'b1;
                drain_cnt <= drain_cnt + 4'd1;
                if (drain_cnt == 4'd15) begin
                    drain_active <= 1'b0;
                end
            end
            if (valid_in && in_cnt == 5'd31) begin
                drain_active <= 1'b1;
                drain_cnt    <= '0;
            end
        end
    end
endmodule

// File: tb/tb_butterfly10.sv
// Bench for butterfly10: frames are built as 512-sample arrays and the expected output
// stream is computed directly from X[n]+X[n+256] / X[n]-X[n+256].
module tb_butterfly10;
    logic         clk = 1'b0;
    logic         rstn;
    logic         valid_in;
    logic [143:0] din_i, din_q;
    logic [207:0] dout_i, dout_q;
    logic         valid_out;

    always #5 clk = ~clk;

    butterfly10 dut (
        .clk(clk), .rstn(rstn), .valid_in(valid_in),
        .din_i(din_i), .din_q(din_q),
        .dout_i(dout_i), .dout_q(dout_q), .valid_out(valid_out)
    );

    int fi [2][512];
    int fq [2][512];
    logic [415:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int out_cnt = 0;
    int push_cnt = 0;
    logic [12:0] first_sum_i, first_sum_q, first_dif_i, first_dif_q;

    task automatic check_vec(input string tag, input logic [415:0] obs, input logic [415:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check13(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] to13(input int v);
        return v[12:0];
    endfunction

    // mode 0 random, 1 constant, 2 distinct halves, 3 min sums, 4 max differences
    task automatic gen_frame(input int f, input int mode);
        for (int n = 0; n < 512; n++) begin
            fi[f][n] = int'($urandom_range(0, 511)) - 256;
            fq[f][n] = int'($urandom_range(0, 511)) - 256;
            case (mode)
                1: begin fi[f][n] = 1; fq[f][n] = 0; end
                2: begin
                    fi[f][n] = (n < 256) ? 100 : -50;
                    fq[f][n] = (n < 256) ? -20 : 30;
                end
                3: fi[f][n] = -256;
                4: fi[f][n] = (n < 256) ? 255 : -256;
                default: ;
            endcase
        end
    endtask

    // Output block b: sums for b<16 (n = 16b+k), differences for b>=16 (n = 16(b-16)+k).
    task automatic push_block(input int f, input int b);
        logic [207:0] ei, eq;
        int n;
        ei = '0;
        eq = '0;
        for (int k = 0; k < 16; k++) begin
            n = 16 * (b % 16) + k;
            if (b < 16) begin
                ei[k*13 +: 13] = to13(fi[f][n] + fi[f][n+256]);
                eq[k*13 +: 13] = to13(fq[f][n] + fq[f][n+256]);
            end else begin
                ei[k*13 +: 13] = to13(fi[f][n] - fi[f][n+256]);
                eq[k*13 +: 13] = to13(fq[f][n] - fq[f][n+256]);
            end
        end
        exp_q.push_back({ei, eq});
        push_cnt++;
    endtask

    task automatic push_frame(input int f);
        for (int b = 0; b < 32; b++) push_block(f, b);
    endtask

    task automatic drive(input int f, input logic v, input int b);
        int x, y;
        @(negedge clk);
        valid_in = v;
        for (int k = 0; k < 16; k++) begin
            if (v) begin
                x = fi[f][16*b+k];
                y = fq[f][16*b+k];
            end else begin
                x = int'($urandom);
                y = int'($urandom);
            end
            din_i[k*9 +: 9] = x[8:0];
            din_q[k*9 +: 9] = y[8:0];
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic run_blocks(input int f, input int nblk, input bit gap, input bit overlap);
        for (int b = 0; b < nblk; b++) begin
            if (gap && b > 0) begin
                drive(f, 1'b0, 0);
                after_edge();
                check_bit($sformatf("gap_vout_b%0d", b), valid_out, 1'b0);
            end
            drive(f, 1'b1, b);
            after_edge();
            check_bit($sformatf("vout_b%0d", b), valid_out, (b >= 16) || (overlap && b < 16));
            if (b == 16) begin
                first_sum_i = dout_i[12:0];
                first_sum_q = dout_q[12:0];
            end
        end
    endtask

    task automatic drain_check();
        for (int c = 0; c < 16; c++) begin
            drive(0, 1'b0, 0);
            after_edge();
            check_bit($sformatf("drain_vout_c%0d", c), valid_out, 1'b1);
            if (c == 0) begin
                first_dif_i = dout_i[12:0];
                first_dif_q = dout_q[12:0];
            end
        end
        drive(0, 1'b0, 0);
        after_edge();
        check_bit("drain_end_vout", valid_out, 1'b0);
    endtask

    always @(negedge clk) begin
        if (valid_out) begin
            out_cnt++;
            check_bit("out_was_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                check_vec($sformatf("out_blk%0d", out_cnt), {dout_i, dout_q}, exp_q.pop_front());
            end
        end
    end

    initial begin
        int cnt0;
        rstn = 1'b1;
        valid_in = 1'b0;
        din_i = '0;
        din_q = '0;
        repeat (5) begin
            after_edge();
            check_bit("rst_vout", valid_out, 1'b0);
            check_vec("rst_dout", {dout_i, dout_q}, '0);
        end
        @(negedge clk);
        rstn = 1'b0;
        repeat (4) begin
            drive(0, 1'b0, 0);
            after_edge();
            check_bit("idle_vout", valid_out, 1'b0);
            check_vec("idle_dout", {dout_i, dout_q}, '0);
        end

        gen_frame(0, 1);
        push_frame(0);
        run_blocks(0, 32, 1'b0, 1'b0);
        drain_check();
        check13("const_sum_i", first_sum_i, 13'd2);
        check13("const_sum_q", first_sum_q, 13'd0);
        check13("const_dif_i", first_dif_i, 13'd0);

        gen_frame(0, 2);
        push_frame(0);
        run_blocks(0, 32, 1'b0, 1'b0);
        drain_check();
        check13("halves_sum_i", first_sum_i, 13'd50);
        check13("halves_sum_q", first_sum_q, 13'd10);
        check13("halves_dif_i", first_dif_i, 13'd150);
        check13("halves_dif_q", first_dif_q, 13'h1FCE);

        gen_frame(0, 3);
        push_frame(0);
        run_blocks(0, 32, 1'b0, 1'b0);
        drain_check();
        check13("min_sum_i", first_sum_i, 13'h1E00);

        gen_frame(0, 4);
        push_frame(0);
        run_blocks(0, 32, 1'b0, 1'b0);
        drain_check();
        check13("max_dif_i", first_dif_i, 13'h01FF);

        cnt0 = out_cnt;
        gen_frame(0, 0);
        push_frame(0);
        run_blocks(0, 32, 1'b1, 1'b0);
        drain_check();
        check_val("gapped_block_count", out_cnt - cnt0, 32);

        cnt0 = out_cnt;
        gen_frame(0, 0);
        gen_frame(1, 0);
        push_frame(0);
        push_frame(1);
        run_blocks(0, 32, 1'b0, 1'b0);
        run_blocks(1, 32, 1'b0, 1'b1);
        drain_check();
        check_val("b2b_block_count", out_cnt - cnt0, 64);

        gen_frame(0, 0);
        for (int b = 0; b < 4; b++) push_block(0, b);
        run_blocks(0, 20, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        valid_in = 1'b1;
        after_edge();
        check_bit("midrst_vout", valid_out, 1'b0);
        check_vec("midrst_dout", {dout_i, dout_q}, '0);
        @(negedge clk);
        rstn = 1'b0;
        valid_in = 1'b0;
        gen_frame(1, 0);
        push_frame(1);
        run_blocks(1, 32, 1'b0, 1'b0);
        drain_check();

        repeat (4) after_edge();
        check_val("queue_drained", exp_q.size(), 0);
        check_val("total_blocks", out_cnt, push_cnt);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
